// File: rtl/seven_seg_scan_ctrl.sv
// Scans NUM_DIGITS digit codes onto one shared 7-seg decoder with per-slot blanking.
// Frames arrive by valid/ready and are double-buffered, swapping in only at frame start.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lzs,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [5*NUM_DIGITS-1:0] upd_codes,
  output logic [4:0]              dig_code,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [4:0]    BLANK_CODE = 5'd23;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][4:0]   act_q, act_d, pend_q, pend_d, eff;
  logic                         pend_full_q, pend_full_d;
  logic [4:0]                   code_q, code_d;
  logic [NUM_DIGITS-1:0]        an_q, an_d;
  logic                         fd_q, fd_d;
  logic                         load, accept, supp;

  // Swap point: first blank cycle of slot 0, or any cycle while idle.
  assign load      = pend_full_q &&
                     (state_q == IDLE || (state_q == BLANK && idx_q == '0 && cnt_q == '0));
  assign upd_ready = !pend_full_q || load;
  assign accept    = upd_valid && upd_ready;

  always_comb begin
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (load) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = upd_codes;
      pend_full_d = 1'b1;
    end
  end

  // Blank zeros from the top digit down until the first nonzero code.
  always_comb begin
    eff  = act_d;
    supp = lzs;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (supp && act_d[i] == 5'd0) begin
        eff[i] = BLANK_CODE;
      end else begin
        supp = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      state_d = (cnt_d < BLANK_END) ? BLANK : SHOW;
    end
  end

  // Outputs are computed from next state so they line up with state_q.
  always_comb begin
    an_d   = '1;
    code_d = BLANK_CODE;
    fd_d   = 1'b0;
    if (state_d == SHOW) begin
      an_d[idx_d] = ~dig_en[idx_d];
      code_d      = eff[idx_d];
      fd_d        = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      act_q       <= {NUM_DIGITS{BLANK_CODE}};
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      code_q      <= BLANK_CODE;
      an_q        <= '1;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      code_q      <= code_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
    end
  end

  assign dig_code   = code_q;
  assign anode_n    = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed phases plus random traffic, every cycle
// compared against a frame-position model of the display.
module tb_seven_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int SC = 8;
  localparam int BC = 2;
  localparam int FR = N * SC;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           lzs = 1'b0;
  logic           upd_valid = 1'b0;
  logic           upd_ready;
  logic           frame_done;
  logic [N-1:0]   dig_en = '1;
  logic [N-1:0]   anode_n;
  logic [5*N-1:0] upd_codes = '0;
  logic [4:0]     dig_code;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(SC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lzs(lzs), .dig_en(dig_en),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_codes(upd_codes),
    .dig_code(dig_code), .anode_n(anode_n), .frame_done(frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt;

  // Model: running flag plus position within the frame (slot*SC + cycle).
  int m_act [N];
  int m_pend[N];
  bit m_pfull, m_run, m_acc;
  int m_pos;

  function automatic int eff(int i);
    if (i == 0 || !lzs) return m_act[i];
    for (int j = i; j < N; j++) if (m_act[j] != 0) return m_act[i];
    return 23;
  endfunction

  function automatic logic [5*N-1:0] rand_frame();
    logic [5*N-1:0] f;
    for (int i = 0; i < N; i++)
      f[5*i +: 5] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    bit ld;
    int e_code;
    logic [N-1:0] e_an;
    bit e_fd, e_rdy;
    m_acc = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_pfull = 0;
      for (int i = 0; i < N; i++) m_act[i] = 23;
    end else begin
      ld    = m_pfull && (!m_run || m_pos == 0);
      m_acc = upd_valid && (!m_pfull || ld);
      if (ld) begin
        m_act = m_pend;
        m_pfull = 0;
      end
      if (m_acc) begin
        for (int i = 0; i < N; i++) m_pend[i] = int'(upd_codes[5*i +: 5]);
        m_pfull = 1;
      end
      if (!enable) begin
        m_run = 0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FR;
      end
    end
    e_an = '1; e_code = 23; e_fd = 0;
    if (m_run && (m_pos % SC) >= BC) begin
      e_an[m_pos / SC] = ~dig_en[m_pos / SC];
      e_code = eff(m_pos / SC);
      e_fd = (m_pos == FR - 1);
    end
    e_rdy = !m_pfull || !m_run || m_pos == 0;
    @(posedge clk);
    #1;
    check("anode_n", 32'(anode_n), 32'(e_an));
    check("dig_code", 32'(dig_code), 32'(e_code));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("upd_ready", 32'(upd_ready), 32'(e_rdy));
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic send_frame(input logic [5*N-1:0] f);
    int w = 0;
    upd_valid = 1'b1;
    upd_codes = f;
    do begin
      step();
      w++;
    end while (!m_acc && w < 4 * FR);
    check("send_accept", 32'(m_acc), 32'd1);
    upd_valid = 1'b0;
  endtask

  task automatic run_until_pos(input int p);
    int w = 0;
    while (!(m_run && m_pos == p) && w < 4 * FR) begin
      step();
      w++;
    end
    check("reach_pos", 32'(m_pos), 32'(p));
  endtask

  initial begin
    // Reset held with enable high.
    rst_n = 1'b0; enable = 1'b1;
    repeat (4) step();

    // Basic scan of {3,2,1,0}, loaded while idle.
    rst_n = 1'b1; enable = 1'b0;
    send_frame({5'd3, 5'd2, 5'd1, 5'd0});
    step();
    enable = 1'b1; dig_en = 4'hF; lzs = 1'b0;
    fd_cnt = 0;
    repeat (2 * FR) step();
    check("fd_count", 32'(fd_cnt), 32'd2);

    // Double buffer: A mid-frame, B held until the boundary.
    run_until_pos(10);
    send_frame(rand_frame());
    send_frame(rand_frame());
    repeat (2 * FR) step();

    // Leading-zero suppression.
    lzs = 1'b1;
    send_frame({5'd0, 5'd0, 5'd5, 5'd0});
    repeat (2 * FR) step();
    send_frame({5'd0, 5'd0, 5'd0, 5'd0});
    repeat (2 * FR) step();
    send_frame({5'd0, 5'd12, 5'd0, 5'd0});
    repeat (2 * FR) step();

    // Digit mask, then drop enable in slot 2 and re-enable.
    lzs = 1'b0; dig_en = 4'b0101;
    send_frame({5'd9, 5'd8, 5'd7, 5'd6});
    repeat (2 * FR) step();
    run_until_pos(2 * SC + BC + 1);
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (SC + 2) step();

    // Reset mid-SHOW with pending full.
    dig_en = 4'hF;
    run_until_pos(SC + BC + 1);
    send_frame({5'd4, 5'd4, 5'd4, 5'd4});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    repeat (FR + 4) step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if (enable) enable = ($urandom_range(0, 99) != 0);
      else        enable = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 63) == 0) lzs = ~lzs;
      if ($urandom_range(0, 63) == 0) dig_en = N'($urandom);
      if (!upd_valid || m_acc) begin
        upd_valid = ($urandom_range(0, 7) == 0);
        upd_codes = rand_frame();
      end
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    upd_valid = 1'b0; rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
